// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory port sequencer: boot loading, then PC fetch control
// with stall, branch redirect, halt and reload.
module imem_fetch_ctrl #(
    parameter int              DEPTH_LOG2 = 6,
    parameter int              PC_W       = DEPTH_LOG2 + 2,
    parameter int              DATA_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  LdValid,
    input  logic [DATA_W-1:0]     LdData,
    input  logic                  LdLast,
    output logic                  LdReady,
    input  logic                  Stall,
    input  logic                  BranchTaken,
    input  logic [PC_W-1:0]       BranchTarget,
    input  logic                  HaltReq,
    input  logic                  ReloadReq,
    output logic [DEPTH_LOG2-1:0] MemAddr,
    output logic                  MemWrEn,
    output logic [DATA_W-1:0]     MemWrData,
    output logic [PC_W-1:0]       PC,
    output logic                  FetchValid,
    output logic [DEPTH_LOG2:0]   LoadCount,
    output logic [1:0]            State
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_e;

    localparam logic [DEPTH_LOG2-1:0] PTR_MAX = '1;
    localparam logic [PC_W-1:0]       WORD_MASK = ~PC_W'(3);

    state_e                state_q, state_d;
    logic [PC_W-1:0]       pc_q, pc_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic [DEPTH_LOG2:0]   cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_LOAD;
            pc_q    <= RESET_PC;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        LdReady    = 1'b0;
        MemWrEn    = 1'b0;
        FetchValid = 1'b0;
        MemAddr    = pc_q[PC_W-1:2];
        MemWrData  = LdData;

        unique case (state_q)
            ST_LOAD: begin
                LdReady = 1'b1;
                MemAddr = ptr_q;
                // Reload wins over a same-cycle loader word
                if (ReloadReq) begin
                    ptr_d = '0;
                    cnt_d = '0;
                    pc_d  = RESET_PC;
                end else if (LdValid) begin
                    MemWrEn = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (LdLast || ptr_q == PTR_MAX) begin
                        state_d = ST_RUN;
                        pc_d    = RESET_PC;
                    end
                end
            end
            ST_RUN: begin
                FetchValid = 1'b1;
                if (ReloadReq) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    pc_d    = RESET_PC;
                end else if (HaltReq) begin
                    state_d = ST_HALT;
                end else if (BranchTaken) begin
                    pc_d = BranchTarget & WORD_MASK;
                end else if (!Stall) begin
                    pc_d = pc_q + PC_W'(4);
                end
            end
            ST_HALT: begin
                if (ReloadReq) begin
                    state_d = ST_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    pc_d    = RESET_PC;
                end
            end
            default: begin
                state_d = ST_LOAD;
                ptr_d   = '0;
                cnt_d   = '0;
                pc_d    = RESET_PC;
            end
        endcase
    end

    assign PC        = pc_q;
    assign LoadCount = cnt_q;
    assign State     = state_q;

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Sequencing controller for the 64x32-bit instruction memory and program counter. It owns the single memory address port, first sharing it with a boot loader that streams program words into the memory. It then hands the port to the fetch path, where it sequences the byte-addressed PC with stall, branch redirect, halt and reload control. It sits between the loader/debug logic, the instruction memory and the decode stage of the MIPS core.

## Interface
Parameters:
- DEPTH_LOG2, 6, log2 of memory depth in words (64 words)
- PC_W, 8, PC width in bits; always DEPTH_LOG2+2
- DATA_W, 32, instruction word width
- RESET_PC, 0, first fetch byte address after load completes; multiple of 4

Ports:
- CLK  in  1  system clock; all state updates on rising edge
- RST_N  in  1  asynchronous, active-low reset
- LdValid  in  1  loader word valid
- LdData  in  DATA_W  loader word
- LdLast  in  1  qualifies LdValid: this is the final program word
- LdReady  out  1  controller accepts a loader word this cycle
- Stall  in  1  hold PC (fetch stage not advancing)
- BranchTaken  in  1  redirect PC this cycle
- BranchTarget  in  PC_W  redirect byte address
- HaltReq  in  1  stop fetching
- ReloadReq  in  1  return to load mode
- MemAddr  out  DEPTH_LOG2  word address to instruction memory
- MemWrEn  out  1  memory write strobe
- MemWrData  out  DATA_W  memory write data
- PC  out  PC_W  current fetch byte address
- FetchValid  out  1  Memory[MemAddr] is a valid instruction for PC
- LoadCount  out  DEPTH_LOG2+1  number of words written in the current/last load
- State  out  2  00 LOAD, 01 RUN, 10 HALT

## Operation
- Reset: State=LOAD, PC=RESET_PC, load pointer=0, LoadCount=0. Combinational outputs derive from those registers: LdReady=1, FetchValid=0, MemWrEn=0.
- LOAD:
  - LdReady=1.
  - Handshake = LdValid & LdReady. MemWrEn = handshake, combinationally. MemAddr = load pointer. MemWrData = LdData.
  - On each handshake: load pointer+1, LoadCount+1.
  - On a handshake with LdLast=1, or with load pointer=63: next State=RUN, PC<=RESET_PC.
  - Words beyond 64 are impossible: the 64th word forces RUN regardless of LdLast.
- RUN:
  - LdReady=0. MemWrEn=0. MemAddr=PC[PC_W-1:2]. FetchValid=1.
  - Next PC by priority:
    1. ReloadReq → State=LOAD, load pointer=0, LoadCount=0, PC=RESET_PC
    2. HaltReq → State=HALT, PC held
    3. BranchTaken → PC={BranchTarget[PC_W-1:2],2'b00}; low two target bits are ignored
    4. Stall → PC held
    5. otherwise PC+4 modulo 2^PC_W; 252 wraps to 0
  - A branch overrides a stall.
- HALT:
  - FetchValid=0. MemAddr=PC[PC_W-1:2]. PC frozen.
  - ReloadReq → LOAD, as above. Stall, BranchTaken and HaltReq are ignored.
  - Leaving HALT requires ReloadReq or reset.
- ReloadReq is also accepted in LOAD: load pointer and LoadCount restart at 0, and any handshake in that cycle is dropped (MemWrEn=0).
- LdValid outside LOAD is ignored; no write occurs.

## Timing
- Loader write takes effect on the same edge as the handshake; zero added latency.
- First RUN cycle directly follows the edge of the last-word handshake. PC=RESET_PC and FetchValid=1 in that cycle.
- Fetch: memory read is combinational, so the instruction for PC is valid in the same cycle FetchValid=1.
- Redirect latency: one edge. Branch sampled at edge N gives PC=target during cycle N+1. There is no delay slot generated here.
- HaltReq sampled at edge N: FetchValid=0 from cycle N+1; the instruction at PC in cycle N is the last valid one.
- RST_N assertion mid-load or mid-run: outputs take reset values immediately, without a clock. Deassertion is synchronised externally; the first update is on the first rising CLK after release.
- All registers (State, PC, load pointer, LoadCount) are clocked; every other output is a combinational decode of State and the inputs.

## Test plan
- Reset, then load 3 words (0x20080005, 0x20090003, 0x01095020) with LdLast on the 3rd → MemWrEn pulses at addresses 0,1,2; LoadCount=3. Next cycle State=01, PC=0, FetchValid=1.
- Load 64 words with LdLast never asserted → forced to RUN after word 64, LoadCount=64. Free-run 65 cycles → PC sequence 0,4,…,252,0.
- In RUN at PC=8, assert Stall 3 cycles → PC stays 8. Then BranchTaken with target 0x2B plus Stall → next PC=0x28.
- In RUN at PC=12, assert HaltReq and BranchTaken together → State=HALT, PC=12, FetchValid=0. Further branch inputs are ignored until ReloadReq → LOAD, PC=0, LoadCount=0.
- Drop RST_N asynchronously between clock edges mid-load (after 5 words) → State=LOAD, LoadCount=0, PC=0 before the next edge. Then reload 2 words → writes start at address 0.
- With LdValid=1 held in RUN → MemWrEn stays 0 and memory contents are unchanged.
